// File: rtl/mod_adjust_counter_pkg.sv
// Shared types and constants for the alarm-clock adjust counters: repeat FSM
// encodings, adjust direction, standard field moduli and default repeat timing.
package mod_adjust_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HR24 = 24;
  localparam int MOD_HR12 = 12;

  localparam int DEF_RPT_DELAY = 50;
  localparam int DEF_RPT_RATE  = 10;

  // Both buttons pressed together is deliberately treated as no request.
  function automatic dir_e decode_dir(input logic up, input logic down);
    if (up && !down) return DIR_UP;
    if (down && !up) return DIR_DN;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/mod_adjust_counter_adjust_repeat_fsm.sv
// Press-and-hold auto-repeat engine: one step on press, a step after RPT_DELAY
// ticks, then one step every RPT_RATE ticks while the same direction is held.
module adjust_repeat_fsm
  import mod_adjust_counter_pkg::*;
#(
  parameter int RPT_DELAY = DEF_RPT_DELAY,
  parameter int RPT_RATE  = DEF_RPT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic up,
  input  logic down,
  input  logic tick,
  input  logic abort,
  output logic step_up,
  output logic step_dn
);

  localparam int CNT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(RPT_RATE - 1);

  rpt_state_e    state_q, state_d;
  dir_e          dir_q, dir_d, dir_req;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_NONE;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_comb begin
    dir_req    = decode_dir(up, down);
    state_d    = state_q;
    dir_d      = dir_q;
    tick_cnt_d = tick_cnt_q;
    fire       = 1'b0;
    if (abort) begin
      state_d    = ST_IDLE;
      dir_d      = DIR_NONE;
      tick_cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (dir_req != DIR_NONE) begin
        fire       = 1'b1;
        dir_d      = dir_req;
        tick_cnt_d = '0;
        state_d    = ST_DELAY;
      end
    end else if (dir_req == DIR_NONE) begin
      state_d    = ST_IDLE;
      dir_d      = DIR_NONE;
      tick_cnt_d = '0;
    end else if (dir_req != dir_q) begin
      // A direction change while held restarts the press sequence.
      fire       = 1'b1;
      dir_d      = dir_req;
      tick_cnt_d = '0;
      state_d    = ST_DELAY;
    end else if (tick) begin
      if (tick_cnt_q == ((state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
        fire       = 1'b1;
        tick_cnt_d = '0;
        state_d    = ST_REPEAT;
      end else begin
        tick_cnt_d = tick_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    step_up = fire && (dir_d == DIR_UP);
    step_dn = fire && (dir_d == DIR_DN);
  end

endmodule

// File: rtl/mod_adjust_counter.sv
// Modulo-MODULUS up/down counter for one alarm-clock time field, with cascade
// carry/borrow, clear/load and a press-and-hold adjust engine.
module mod_adjust_counter
  import mod_adjust_counter_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int MODULUS   = 60,
  parameter int RPT_DELAY = DEF_RPT_DELAY,
  parameter int RPT_RATE  = DEF_RPT_RATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_en,
  input  logic             up,
  input  logic             down,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] WRAP2   = WIDTH'(MODULUS - 2);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             step_up, step_dn;

  adjust_repeat_fsm #(
    .RPT_DELAY(RPT_DELAY),
    .RPT_RATE (RPT_RATE)
  ) u_rpt (
    .clk    (clk),
    .reset  (reset),
    .up     (up),
    .down   (down),
    .tick   (tick),
    .abort  (clear | load),
    .step_up(step_up),
    .step_dn(step_dn)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    end else begin
      // Net delta of the cascade strobe and an adjust step; +1 and -1 cancel.
      unique case ({cnt_en, step_up, step_dn})
        3'b110: begin
          if (count_q >= WRAP2) begin
            count_d = count_q - WRAP2;
            carry_d = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(2);
          end
        end
        3'b100, 3'b010: begin
          if (count_q == MAX_VAL) begin
            count_d = '0;
            carry_d = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        3'b001: begin
          if (count_q == '0) begin
            count_d  = MAX_VAL;
            borrow_d = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  assign count   = count_q;
  assign carry   = carry_q;
  assign borrow  = borrow_q;
  assign at_max  = (count_q == MAX_VAL);
  assign at_zero = (count_q == '0);

endmodule
